countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Settable H:M:S countdown timer. It counts the opposite direction to the up-counting stopwatch: load a time, count down once per second, flag expiry at 00:00:00.
- Sits beside the stopwatch on the binary-clock board.
- Runs on the 50 MHz board clock. An internal clock-enable divider produces the 1 Hz tick; no derived clocks.
- Hours/minutes/seconds outputs use the same widths as the stopwatch, so they can drive the same binary LED display path.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
TICK_HZ, 1, countdown rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  one-cycle strobe: capture load_* into the time registers
load_hours  input  5  hours to load, 0..23
load_minutes  input  6  minutes to load, 0..59
load_seconds  input  6  seconds to load, 0..59
start  input  1  one-cycle strobe: begin or resume counting
pause  input  1  one-cycle strobe: halt counting, hold time
clear  input  1  one-cycle strobe: zero everything, return to IDLE
hours  output  5  current hours
minutes  output  6  current minutes
seconds  output  6  current seconds
running  output  1  high while in RUN
done  output  1  one-cycle pulse on reaching 00:00:00
alarm  output  1  level, high in EXPIRED until clear or load

Behaviour:
- Interface: one clock (clk); reset is asynchronous, active-low (rst_n).
- Reset:
  - state = IDLE.
  - hours, minutes, seconds = 0.
  - divider = 0.
  - running, done, alarm = 0.
- All outputs are registered. Effects appear the cycle after the strobe is sampled.
- States: IDLE, RUN, PAUSED, EXPIRED. running = (state==RUN); alarm = (state==EXPIRED).
- Strobe priority within one cycle: clear > load > pause > start.
- clear, in any state:
  - time = 0, divider = 0, state = IDLE.
  - done is forced 0 that cycle.
- load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - Fields saturate: hours > 23 loads 23; minutes or seconds > 59 loads 59.
  - divider = 0, state = IDLE, alarm drops.
- start:
  - From IDLE or PAUSED with time != 0: go to RUN.
  - From IDLE the divider is already 0, so the first decrement comes after a full DIV cycles.
  - From PAUSED the divider resumes from its held value.
  - start with time == 0: ignored, stay put.
  - start in RUN or EXPIRED: ignored.
- pause:
  - In RUN: go to PAUSED, divider and time frozen.
  - Ignored in other states.
- Divider:
  - In RUN, divider increments each cycle. tick = (divider == DIV-1); divider wraps to 0 on tick.
  - Frozen outside RUN.
- Decrement on tick:
  - seconds > 0: seconds-1.
  - Else seconds = 59 and: if minutes > 0, minutes-1; else minutes = 59 and hours-1.
  - hours never underflows, because RUN is never entered with time == 0.
- Expiry:
  - When a tick produces 00:00:00, the next state is EXPIRED.
  - done = 1 for exactly that one cycle. alarm rises in the same cycle.
- Tick and pause in the same cycle: the decrement is applied, then the state goes to PAUSED. If that decrement reaches zero, EXPIRED wins and pause is ignored.
- Tick and clear in the same cycle: clear wins, no decrement, no done.
- Reset asserted mid-count: immediate return to reset values regardless of clk.
- Width rules: all arithmetic stays in field width. The divider is clog2(DIV) bits wide.

Decomposition:
- Shared package holds:
  - constants MAX_HOURS = 23 and MAX_MIN_SEC = 59;
  - the 2-bit state encoding (IDLE = 0, RUN = 1, PAUSED = 2, EXPIRED = 3);
  - field widths HOURS_W = 5 and MIN_SEC_W = 6, shared with the stopwatch.
- One sub-module: countdown_tick_gen.
  - Parameter DIV.
  - Inputs clk, rst_n, enable, restart.
  - Output tick.
  - Holds the divider; restart zeroes it.
- The top level holds the FSM, the saturating load logic and the borrow chain.

Test Plan (CLK_HZ = 4, TICK_HZ = 1, so DIV = 4):
- Load 00:00:03, start -> running next cycle; seconds go 2, 1, 0 at 4-cycle spacing; done pulses once with the final update; alarm stays 1; running = 0.
- Load 01:00:00, start, wait one tick -> 00:59:59; load 00:01:00 and let it tick -> 00:00:59 (borrow chain through minutes and hours).
- Load hours = 31, minutes = 63, seconds = 60 -> reads 23:59:59 (saturation). Load 00:00:00, then start -> stays IDLE, running = 0, no done.
- Load 00:00:05, start, pause 2 cycles after start, wait 10 cycles, start -> first decrement to 4 comes 2 cycles after resume (divider held across pause).
- Load 00:00:01, start, assert pause on the tick cycle -> EXPIRED, done pulses, not PAUSED. Repeat with clear on the tick cycle -> IDLE, 00:00:00, no done.
- While RUN at 00:00:07, drop rst_n mid-cycle -> outputs 0 and IDLE asynchronously. Release, then load 00:00:02 -> normal operation; load while RUN is ignored.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: field widths, limits and state encoding shared with the stopwatch
package countdown_timer_pkg;
    localparam int HOURS_W   = 5;
    localparam int MIN_SEC_W = 6;
    localparam logic [HOURS_W-1:0]   MAX_HOURS   = 5'd23;
    localparam logic [MIN_SEC_W-1:0] MAX_MIN_SEC = 6'd59;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;
    function automatic logic [MIN_SEC_W-1:0] sat_min_sec(input logic [MIN_SEC_W-1:0] v);
        return (v > MAX_MIN_SEC) ? MAX_MIN_SEC : v;
    endfunction
    function automatic logic [HOURS_W-1:0] sat_hours(input logic [HOURS_W-1:0] v);
        return (v > MAX_HOURS) ? MAX_HOURS : v;
    endfunction
endpackage

// File: rtl/countdown_tick_gen.sv
// countdown_tick_gen: clock-enable divider, tick on the last count of every DIV enabled cycles
module countdown_tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt;
    assign tick = enable && !restart && (cnt == LAST);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (restart)
            cnt <= '0;
        else if (enable)
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: settable H:M:S countdown with pause/resume and expiry alarm
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [HOURS_W-1:0]   load_hours,
    input  logic [MIN_SEC_W-1:0] load_minutes,
    input  logic [MIN_SEC_W-1:0] load_seconds,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 clear,
    output logic [HOURS_W-1:0]   hours,
    output logic [MIN_SEC_W-1:0] minutes,
    output logic [MIN_SEC_W-1:0] seconds,
    output logic                 running,
    output logic                 done,
    output logic                 alarm
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    state_t state, state_nxt;
    logic [HOURS_W-1:0]   h_nxt, h_dec;
    logic [MIN_SEC_W-1:0] m_nxt, m_dec, s_nxt, s_dec;
    logic                 done_nxt, tick, load_ok, time_nz, dec_zero;
    assign load_ok = load && (state != RUN);
    assign time_nz = (hours != '0) || (minutes != '0) || (seconds != '0);
    assign running = (state == RUN);
    assign alarm   = (state == EXPIRED);
    countdown_tick_gen #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state == RUN),
        .restart (clear || load_ok),
        .tick    (tick)
    );
    // borrow chain: seconds wrap to 59 and borrow from minutes, minutes likewise from hours
    always_comb begin
        s_dec    = (seconds != '0) ? seconds - 6'd1 : MAX_MIN_SEC;
        m_dec    = (seconds != '0) ? minutes : ((minutes != '0) ? minutes - 6'd1 : MAX_MIN_SEC);
        h_dec    = (seconds == '0 && minutes == '0) ? hours - 5'd1 : hours;
        dec_zero = (h_dec == '0) && (m_dec == '0) && (s_dec == '0);
    end
    always_comb begin
        state_nxt = state;
        h_nxt     = hours;
        m_nxt     = minutes;
        s_nxt     = seconds;
        done_nxt  = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            h_nxt     = '0;
            m_nxt     = '0;
            s_nxt     = '0;
        end else if (load_ok) begin
            state_nxt = IDLE;
            h_nxt     = sat_hours(load_hours);
            m_nxt     = sat_min_sec(load_minutes);
            s_nxt     = sat_min_sec(load_seconds);
        end else if (state == RUN) begin
            if (tick) begin
                h_nxt = h_dec;
                m_nxt = m_dec;
                s_nxt = s_dec;
            end
            if (tick && dec_zero) begin
                state_nxt = EXPIRED;
                done_nxt  = 1'b1;
            end else if (pause) begin
                state_nxt = PAUSED;
            end
        end else if (start && (state == IDLE || state == PAUSED) && time_nz) begin
            state_nxt = RUN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            hours   <= '0;
            minutes <= '0;
            seconds <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            hours   <= h_nxt;
            minutes <= m_nxt;
            seconds <= s_nxt;
            done    <= done_nxt;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of load, countdown, borrow, pause, expiry and reset
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [4:0] load_hours = '0;
    logic [5:0] load_minutes = '0, load_seconds = '0;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic       running, done, alarm;
    int         total = 0, bad = 0;

    countdown_timer #(.CLK_HZ(4), .TICK_HZ(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (load),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .load_seconds (load_seconds),
        .start        (start),
        .pause        (pause),
        .clear        (clear),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .running      (running),
        .done         (done),
        .alarm        (alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic l, input logic st, input logic p, input logic c);
        load = l; start = st; pause = p; clear = c;
        step(1);
        load = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load_hours = 5'(h); load_minutes = 6'(m); load_seconds = 6'(s);
        strobe(1, 0, 0, 0);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, hours, h);
        chk({tag, ".m"}, minutes, m);
        chk({tag, ".s"}, seconds, s);
    endtask

    task automatic chk_flags(input string tag, input int r, input int d, input int a);
        chk({tag, ".run"}, running, r);
        chk({tag, ".done"}, done, d);
        chk({tag, ".alarm"}, alarm, a);
    endtask

    initial begin
        #12;
        chk_time("rst", 0, 0, 0);
        chk_flags("rst", 0, 0, 0);
        rst_n = 1'b1;
        step(1);

        do_load(0, 0, 3);
        strobe(0, 1, 0, 0);
        chk_flags("t1.start", 1, 0, 0);
        step(3);
        chk_time("t1.hold", 0, 0, 3);
        step(1);
        chk_time("t1.s2", 0, 0, 2);
        step(4);
        chk_time("t1.s1", 0, 0, 1);
        chk_flags("t1.s1", 1, 0, 0);
        step(4);
        chk_time("t1.s0", 0, 0, 0);
        chk_flags("t1.exp", 0, 1, 1);
        step(1);
        chk_flags("t1.after", 0, 0, 1);
        strobe(0, 1, 0, 0);
        chk_flags("t1.startexp", 0, 0, 1);

        do_load(1, 0, 0);
        chk_flags("t2.load", 0, 0, 0);
        strobe(0, 1, 0, 0);
        step(4);
        chk_time("t2.borrow_h", 0, 59, 59);
        strobe(0, 0, 1, 0);
        chk_flags("t2.pause", 0, 0, 0);
        do_load(0, 1, 0);
        strobe(0, 1, 0, 0);
        step(4);
        chk_time("t2.borrow_m", 0, 0, 59);
        strobe(0, 0, 0, 1);

        do_load(31, 63, 60);
        chk_time("t3.sat", 23, 59, 59);
        do_load(0, 0, 0);
        strobe(0, 1, 0, 0);
        chk_flags("t3.zero_start", 0, 0, 0);
        step(5);
        chk_time("t3.zero_hold", 0, 0, 0);

        do_load(0, 0, 5);
        strobe(0, 1, 0, 0);
        step(1);
        strobe(0, 0, 1, 0);
        chk_flags("t4.pause", 0, 0, 0);
        step(10);
        chk_time("t4.held", 0, 0, 5);
        strobe(0, 1, 0, 0);
        chk_flags("t4.resume", 1, 0, 0);
        step(1);
        chk_time("t4.pre", 0, 0, 5);
        step(1);
        chk_time("t4.dec", 0, 0, 4);
        strobe(0, 0, 0, 1);
        chk_time("t4.clear", 0, 0, 0);
        chk_flags("t4.clear", 0, 0, 0);

        do_load(0, 0, 1);
        strobe(0, 1, 0, 0);
        step(3);
        strobe(0, 0, 1, 0);
        chk_time("t5.pexp", 0, 0, 0);
        chk_flags("t5.pexp", 0, 1, 1);
        do_load(0, 0, 1);
        chk_flags("t5.reload", 0, 0, 0);
        strobe(0, 1, 0, 0);
        step(3);
        strobe(0, 0, 0, 1);
        chk_time("t5.cclr", 0, 0, 0);
        chk_flags("t5.cclr", 0, 0, 0);

        do_load(0, 0, 7);
        strobe(0, 1, 0, 0);
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk_time("t6.arst", 0, 0, 0);
        chk_flags("t6.arst", 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        do_load(0, 0, 2);
        strobe(0, 1, 0, 0);
        step(2);
        load_seconds = 6'd9;
        strobe(1, 0, 0, 0);
        chk_time("t6.ld_ign", 0, 0, 2);
        chk("t6.ld_ign.run", running, 1);
        step(1);
        chk_time("t6.s1", 0, 0, 1);
        step(4);
        chk_time("t6.s0", 0, 0, 0);
        chk_flags("t6.exp", 0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
